// File: rtl/misr_pkg.sv
`default_nettype none
// ============================================================================
// misr_pkg : register map, CTRL commands and FSM states for misr_session_ctrl
// Rev 1.0
// ============================================================================
package misr_pkg;

    localparam logic [7:0] c_off_ctrl  = 8'h00;
    localparam logic [7:0] c_off_coeff = 8'h40;
    localparam logic [7:0] c_off_sig   = 8'h80;
    localparam logic [7:0] c_off_done  = 8'hC0;

    localparam int c_ctrl_en_bit      = 0;
    localparam int c_ctrl_rst_bit     = 1;
    localparam int c_ctrl_done_in_bit = 2;

    localparam logic [2:0] c_cmd_en      = 3'(1 << c_ctrl_en_bit);
    localparam logic [2:0] c_cmd_rst     = 3'(1 << c_ctrl_rst_bit);
    localparam logic [2:0] c_cmd_done_in = 3'(1 << c_ctrl_done_in_bit);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD     = 4'd1,
        ST_WR_COEFF = 4'd2,
        ST_WR_RST   = 4'd3,
        ST_WR_CLR   = 4'd4,
        ST_WR_EN    = 4'd5,
        ST_STREAM   = 4'd6,
        ST_WR_DONE  = 4'd7,
        ST_POLL     = 4'd8,
        ST_RD_SIG   = 4'd9,
        ST_REPORT   = 4'd10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/misr_word_buf.sv
`default_nettype none
// ============================================================================
// misr_word_buf : session word store with independent write and read pointers
// Rev 1.0
// ============================================================================
module misr_word_buf #(
    parameter int NBIT_DATA = 64,
    parameter int MAX_WORDS = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    input  logic                         wr_en_i,
    input  logic [NBIT_DATA-1:0]         wr_data_i,
    input  logic                         rd_inc_i,
    output logic [NBIT_DATA-1:0]         rd_data_o,
    output logic [$clog2(MAX_WORDS)-1:0] wr_ptr_o
);

    localparam int AW = $clog2(MAX_WORDS);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    logic [NBIT_DATA-1:0] mem_q [MAX_WORDS];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_WORDS; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + c_ptr_one;
            end
            if (rd_inc_i) begin
                rd_ptr_q <= rd_ptr_q + c_ptr_one;
            end
        end
    end

    // Combinational read so the stream word can be registered onto the bus
    assign rd_data_o = mem_q[rd_ptr_q];
    assign wr_ptr_o  = wr_ptr_q;

endmodule
`default_nettype wire

// File: rtl/misr_session_ctrl.sv
`default_nettype none
// ============================================================================
// misr_session_ctrl : runs one MISR signature session over the register bus
// Rev 1.0
// ============================================================================
module misr_session_ctrl
    import misr_pkg::*;
#(
    parameter int                   NBIT_DATA = 64,
    parameter int                   NBIT_ADDR = 64,
    parameter logic [NBIT_ADDR-1:0] BASE_ADDR = NBIT_ADDR'(2**25),
    parameter int                   MAX_WORDS = 16,
    parameter int                   POLL_MAX  = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [NBIT_DATA-1:0]           cfg_coeff_i,
    input  logic [$clog2(MAX_WORDS+1)-1:0] cfg_len_i,
    input  logic [NBIT_DATA-1:0]           cfg_golden_i,
    input  logic                           s_valid_i,
    input  logic [NBIT_DATA-1:0]           s_data_i,
    output logic                           s_ready_o,
    output logic                           m_req_o,
    output logic                           m_we_o,
    output logic [NBIT_ADDR-1:0]           m_addr_o,
    output logic [NBIT_DATA-1:0]           m_data_o,
    input  logic [NBIT_DATA-1:0]           m_data_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           pass_o,
    output logic                           err_o,
    output logic [NBIT_DATA-1:0]           signature_o
);

    localparam int LW = $clog2(MAX_WORDS+1);
    localparam int AW = $clog2(MAX_WORDS);
    localparam int PW = $clog2(POLL_MAX+1);

    localparam logic [NBIT_ADDR-1:0] c_addr_ctrl  = BASE_ADDR + NBIT_ADDR'(c_off_ctrl);
    localparam logic [NBIT_ADDR-1:0] c_addr_coeff = BASE_ADDR + NBIT_ADDR'(c_off_coeff);
    localparam logic [NBIT_ADDR-1:0] c_addr_sig   = BASE_ADDR + NBIT_ADDR'(c_off_sig);
    localparam logic [NBIT_ADDR-1:0] c_addr_done  = BASE_ADDR + NBIT_ADDR'(c_off_done);
    localparam logic [NBIT_DATA-1:0] c_ctrl_en    = NBIT_DATA'(c_cmd_en);
    localparam logic [NBIT_DATA-1:0] c_ctrl_rst   = NBIT_DATA'(c_cmd_rst);
    localparam logic [NBIT_DATA-1:0] c_ctrl_dn    = NBIT_DATA'(c_cmd_done_in);
    localparam logic [LW-1:0]        c_len_one    = LW'(1);
    localparam logic [LW-1:0]        c_len_max    = LW'(MAX_WORDS);
    localparam logic [PW-1:0]        c_poll_one   = PW'(1);
    localparam logic [PW-1:0]        c_poll_last  = PW'(POLL_MAX-1);

    state_t               state_q;
    logic [LW-1:0]        len_q, scnt_q;
    logic [PW-1:0]        pcnt_q;
    logic [NBIT_DATA-1:0] coeff_q, golden_q, sig_q, m_data_q;
    logic [NBIT_ADDR-1:0] m_addr_q;
    logic                 s_ready_q, m_req_q, m_we_q, busy_q, done_q, pass_q, err_q;

    logic                 w_buf_wr, w_buf_rd, w_buf_clr, w_last_word, w_last_stream;
    logic [NBIT_DATA-1:0] w_rd_data;
    logic [AW-1:0]        w_wr_ptr;

    assign w_buf_clr     = (state_q == ST_IDLE);
    assign w_buf_wr      = (state_q == ST_LOAD) && s_ready_q && s_valid_i;
    assign w_last_word   = (LW'(w_wr_ptr) == len_q - c_len_one);
    assign w_last_stream = (scnt_q == len_q - c_len_one);
    assign w_buf_rd      = ((state_q == ST_WR_EN) && (len_q != '0)) ||
                           ((state_q == ST_STREAM) && !w_last_stream);

    misr_word_buf #(
        .NBIT_DATA (NBIT_DATA),
        .MAX_WORDS (MAX_WORDS)
    ) u_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (w_buf_clr),
        .wr_en_i   (w_buf_wr),
        .wr_data_i (s_data_i),
        .rd_inc_i  (w_buf_rd),
        .rd_data_o (w_rd_data),
        .wr_ptr_o  (w_wr_ptr)
    );

    // Bus outputs default to idle each cycle; a transition sets the bus
    // values that belong to the state being entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            scnt_q    <= '0;
            pcnt_q    <= '0;
            coeff_q   <= '0;
            golden_q  <= '0;
            sig_q     <= '0;
            m_data_q  <= '0;
            m_addr_q  <= '0;
            s_ready_q <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            m_req_q  <= 1'b0;
            m_we_q   <= 1'b0;
            m_addr_q <= '0;
            m_data_q <= '0;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        len_q    <= cfg_len_i;
                        coeff_q  <= cfg_coeff_i;
                        golden_q <= cfg_golden_i;
                        pass_q   <= 1'b0;
                        err_q    <= 1'b0;
                        sig_q    <= '0;
                        busy_q   <= 1'b1;
                        if (cfg_len_i > c_len_max) begin
                            err_q   <= 1'b1;
                            state_q <= ST_REPORT;
                        end else if (cfg_len_i == '0) begin
                            {m_req_q, m_we_q} <= 2'b11;
                            m_addr_q <= c_addr_coeff;
                            m_data_q <= cfg_coeff_i;
                            state_q  <= ST_WR_COEFF;
                        end else begin
                            s_ready_q <= 1'b1;
                            state_q   <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_buf_wr && w_last_word) begin
                        s_ready_q <= 1'b0;
                        {m_req_q, m_we_q} <= 2'b11;
                        m_addr_q  <= c_addr_coeff;
                        m_data_q  <= coeff_q;
                        state_q   <= ST_WR_COEFF;
                    end
                end
                ST_WR_COEFF: begin
                    {m_req_q, m_we_q} <= 2'b11;
                    m_addr_q <= c_addr_ctrl;
                    m_data_q <= c_ctrl_rst;
                    state_q  <= ST_WR_RST;
                end
                ST_WR_RST: begin
                    {m_req_q, m_we_q} <= 2'b11;
                    m_addr_q <= c_addr_ctrl;
                    state_q  <= ST_WR_CLR;
                end
                ST_WR_CLR: begin
                    {m_req_q, m_we_q} <= 2'b11;
                    m_addr_q <= c_addr_ctrl;
                    m_data_q <= c_ctrl_en;
                    state_q  <= ST_WR_EN;
                end
                ST_WR_EN, ST_STREAM: begin
                    if ((state_q == ST_WR_EN) ? (len_q == '0) : w_last_stream) begin
                        {m_req_q, m_we_q} <= 2'b11;
                        m_addr_q <= c_addr_ctrl;
                        m_data_q <= c_ctrl_dn;
                        state_q  <= ST_WR_DONE;
                    end else begin
                        m_data_q <= w_rd_data;
                        scnt_q   <= (state_q == ST_WR_EN) ? '0 : scnt_q + c_len_one;
                        state_q  <= ST_STREAM;
                    end
                end
                ST_WR_DONE: begin
                    m_req_q  <= 1'b1;
                    m_addr_q <= c_addr_done;
                    pcnt_q   <= '0;
                    state_q  <= ST_POLL;
                end
                ST_POLL: begin
                    if (m_data_i[0]) begin
                        m_req_q  <= 1'b1;
                        m_addr_q <= c_addr_sig;
                        state_q  <= ST_RD_SIG;
                    end else if (pcnt_q == c_poll_last) begin
                        err_q   <= 1'b1;
                        state_q <= ST_REPORT;
                    end else begin
                        m_req_q  <= 1'b1;
                        m_addr_q <= c_addr_done;
                        pcnt_q   <= pcnt_q + c_poll_one;
                    end
                end
                ST_RD_SIG: begin
                    sig_q   <= m_data_i;
                    pass_q  <= (m_data_i == golden_q);
                    state_q <= ST_REPORT;
                end
                ST_REPORT: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_ready_o   = s_ready_q;
    assign m_req_o     = m_req_q;
    assign m_we_o      = m_we_q;
    assign m_addr_o    = m_addr_q;
    assign m_data_o    = m_data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_o       = err_q;
    assign signature_o = sig_q;

endmodule
`default_nettype wire

// File: tb/tb_misr_session_ctrl.sv
`default_nettype none
// ============================================================================
// tb_misr_session_ctrl : directed bench with a behavioural MISR peripheral
// Rev 1.0
// ============================================================================
module tb_misr_session_ctrl;

    localparam logic [63:0] A_CTRL  = 64'h0200_0000;
    localparam logic [63:0] A_COEFF = 64'h0200_0040;
    localparam logic [63:0] A_SIG   = 64'h0200_0080;
    localparam logic [63:0] A_DONE  = 64'h0200_00C0;
    localparam logic [63:0] COEFF   = 64'h1B;
    // MISR over {0x1,0xA,0xB,0xC}: 0x1 -> 0x8 -> 0x1B -> 0x3A
    localparam logic [63:0] GOLD3   = 64'h3A;
    // MISR over {0x1} alone
    localparam logic [63:0] GOLD0   = 64'h1;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_i, start_i, s_valid_i, s_ready_o;
    logic [63:0] cfg_coeff_i, cfg_golden_i, s_data_i;
    logic [4:0]  cfg_len_i;
    logic        m_req_o, m_we_o, busy_o, done_o, pass_o, err_o;
    logic [63:0] m_addr_o, m_data_o, m_data_i, signature_o;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          req_cnt = 0, done_rd_cnt = 0, sig_rd_cnt = 0;
    int          req0, drd0, srd0, lat;
    logic        never_done;
    logic [63:0] words [4] = '{64'hA, 64'hB, 64'hC, 64'h0};
    wr_t         wr_log [$];
    logic [63:0] st_dat [$];
    int          st_cyc [$];

    logic        p_en = 1'b0, p_done = 1'b0;
    logic [63:0] p_sig = 64'd0, p_coeff = 64'd0;

    misr_session_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .cfg_coeff_i  (cfg_coeff_i),
        .cfg_len_i    (cfg_len_i),
        .cfg_golden_i (cfg_golden_i),
        .s_valid_i    (s_valid_i),
        .s_data_i     (s_data_i),
        .s_ready_o    (s_ready_o),
        .m_req_o      (m_req_o),
        .m_we_o       (m_we_o),
        .m_addr_o     (m_addr_o),
        .m_data_o     (m_data_o),
        .m_data_i     (m_data_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .pass_o       (pass_o),
        .err_o        (err_o),
        .signature_o  (signature_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] misr_step(input logic [63:0] s, input logic [63:0] d,
                                              input logic [63:0] c);
        return {s[62:0], 1'b0} ^ (s[63] ? c : 64'd0) ^ d;
    endfunction

    // Peripheral: compresses the bus data in the EN write cycle and in every
    // non-request cycle while enabled; DONE latches on a DONE_IN write.
    always @(posedge clk) begin
        if (m_req_o && m_we_o && m_addr_o == A_CTRL) begin
            p_en <= m_data_o[0];
            if (m_data_o[1]) begin
                p_sig  <= 64'd0;
                p_done <= 1'b0;
            end else if (m_data_o[0]) begin
                p_sig <= misr_step(p_sig, m_data_o, p_coeff);
            end
            if (m_data_o[2]) p_done <= 1'b1;
        end else if (m_req_o && m_we_o && m_addr_o == A_COEFF) begin
            p_coeff <= m_data_o;
        end else if (!m_req_o && p_en) begin
            p_sig <= misr_step(p_sig, m_data_o, p_coeff);
        end
    end

    assign m_data_i = (m_req_o && !m_we_o && m_addr_o == A_DONE) ? {63'd0, p_done && !never_done} :
                      (m_req_o && !m_we_o && m_addr_o == A_SIG)  ? p_sig : 64'd0;

    always @(negedge clk) begin
        if (m_req_o && m_we_o) wr_log.push_back('{addr: m_addr_o, data: m_data_o, cyc: cyc});
        if (!m_req_o && m_data_o != 64'd0) begin
            st_dat.push_back(m_data_o);
            st_cyc.push_back(cyc);
        end
        if (m_req_o) req_cnt <= req_cnt + 1;
        if (m_req_o && !m_we_o && m_addr_o == A_DONE) done_rd_cnt <= done_rd_cnt + 1;
        if (m_req_o && !m_we_o && m_addr_o == A_SIG)  sig_rd_cnt  <= sig_rd_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // vpat gives s_valid_i for the first six LOAD cycles, MSB first
    task automatic run_session(input int len, input logic [63:0] gold, input logic [5:0] vpat,
                               input bit rst_at1, output int latency);
        int  widx, k, t0;
        bit  hs, seen;
        wr_log.delete();
        st_dat.delete();
        st_cyc.delete();
        req0 = req_cnt;
        drd0 = done_rd_cnt;
        srd0 = sig_rd_cnt;
        @(posedge clk); #1;
        cfg_len_i    = 5'(len);
        cfg_coeff_i  = COEFF;
        cfg_golden_i = gold;
        start_i      = 1'b1;
        s_valid_i    = 1'b0;
        t0 = cyc; widx = 0; k = 0; seen = 1'b0; latency = -1;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            hs = s_valid_i && s_ready_o;
            if (done_o) begin
                latency = cyc - t0;
                seen    = 1'b1;
                break;
            end
            if (rst_at1 && busy_o && !m_req_o && m_data_o == words[1]) begin
                rst_i = 1'b1;
                @(posedge clk); #1;
                rst_i = 1'b0; start_i = 1'b0; s_valid_i = 1'b0;
                @(negedge clk);
                check_val("rst_req", 64'(m_req_o), 64'd0);
                check_val("rst_busy", 64'(busy_o), 64'd0);
                check_val("rst_mdata", m_data_o, 64'd0);
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            if (hs) widx++;
            if (widx < len) begin
                s_valid_i = (k < 6) ? vpat[5-k] : 1'b1;
                s_data_i  = words[widx % 4];
                k++;
            end else begin
                s_valid_i = 1'b0;
                s_data_i  = 64'd0;
            end
        end
        check_val("session_ends", 64'(seen), 64'd1);
    endtask

    task automatic check_bus(input string p, input int len);
        logic [63:0] ea [5] = '{A_COEFF, A_CTRL, A_CTRL, A_CTRL, A_CTRL};
        logic [63:0] ed [5] = '{COEFF, 64'h2, 64'h0, 64'h1, 64'h4};
        check_val({p, "_nwr"}, 64'(wr_log.size()), 64'd5);
        check_val({p, "_nstream"}, 64'(st_dat.size()), 64'(len));
        if (wr_log.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check_val($sformatf("%s_wr%0d_addr", p, i), wr_log[i].addr, ea[i]);
                check_val($sformatf("%s_wr%0d_data", p, i), wr_log[i].data, ed[i]);
            end
            for (int i = 0; i < st_dat.size() && i < len; i++) begin
                check_val($sformatf("%s_st%0d_data", p, i), st_dat[i], words[i]);
                check_val($sformatf("%s_st%0d_cyc", p, i), 64'(st_cyc[i]),
                          64'(wr_log[3].cyc + 1 + i));
            end
            check_val({p, "_wrdone_cyc"}, 64'(wr_log[4].cyc), 64'(wr_log[3].cyc + len + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b0; s_valid_i = 1'b0; s_data_i = 64'd0;
        cfg_len_i = 5'd0; cfg_coeff_i = 64'd0; cfg_golden_i = 64'd0; never_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check_val("rst_busy0", 64'(busy_o), 64'd0);
        check_val("rst_done0", 64'(done_o), 64'd0);
        check_val("rst_pass0", 64'(pass_o), 64'd0);
        check_val("rst_err0", 64'(err_o), 64'd0);
        check_val("rst_sig0", signature_o, 64'd0);
        check_val("rst_req0", 64'(m_req_o), 64'd0);
        check_val("rst_ready0", 64'(s_ready_o), 64'd0);

        // Nominal three-word session
        run_session(3, GOLD3, 6'b111111, 1'b0, lat);
        check_val("t1_lat", 64'(lat), 64'd15);
        check_val("t1_pass", 64'(pass_o), 64'd1);
        check_val("t1_err", 64'(err_o), 64'd0);
        check_val("t1_sig", signature_o, GOLD3);
        check_val("t1_busy", 64'(busy_o), 64'd0);
        check_val("t1_done_rd", 64'(done_rd_cnt - drd0), 64'd1);
        check_val("t1_sig_rd", 64'(sig_rd_cnt - srd0), 64'd1);
        check_bus("t1", 3);
        @(negedge clk);
        check_val("t1_done_pulse", 64'(done_o), 64'd0);
        check_val("t1_pass_held", 64'(pass_o), 64'd1);

        // Golden mismatch
        run_session(3, GOLD3 ^ 64'd1, 6'b111111, 1'b0, lat);
        check_val("t2_pass", 64'(pass_o), 64'd0);
        check_val("t2_err", 64'(err_o), 64'd0);
        check_val("t2_sig", signature_o, GOLD3);

        // Length above MAX_WORDS
        run_session(20, GOLD3, 6'b111111, 1'b0, lat);
        check_val("t3_lat", 64'(lat), 64'd2);
        check_val("t3_nreq", 64'(req_cnt - req0), 64'd0);
        check_val("t3_err", 64'(err_o), 64'd1);
        check_val("t3_pass", 64'(pass_o), 64'd0);
        check_val("t3_sig", signature_o, 64'd0);

        // DONE never set
        never_done = 1'b1;
        run_session(3, GOLD3, 6'b111111, 1'b0, lat);
        never_done = 1'b0;
        check_val("t4_done_rd", 64'(done_rd_cnt - drd0), 64'd255);
        check_val("t4_sig_rd", 64'(sig_rd_cnt - srd0), 64'd0);
        check_val("t4_err", 64'(err_o), 64'd1);
        check_val("t4_pass", 64'(pass_o), 64'd0);

        // Input stalls during LOAD
        run_session(3, GOLD3, 6'b100101, 1'b0, lat);
        check_val("t5_pass", 64'(pass_o), 64'd1);
        check_val("t5_sig", signature_o, GOLD3);
        check_bus("t5", 3);

        // Zero-length session
        run_session(0, GOLD0, 6'b111111, 1'b0, lat);
        check_val("t6_lat", 64'(lat), 64'd9);
        check_val("t6_pass", 64'(pass_o), 64'd1);
        check_val("t6_sig", signature_o, GOLD0);
        check_bus("t6", 0);

        // Reset in STREAM, then a fresh session
        run_session(3, GOLD3, 6'b111111, 1'b1, lat);
        check_val("t7_nwr_after_rst", 64'(wr_log.size()), 64'd4);
        run_session(3, GOLD3, 6'b111111, 1'b0, lat);
        check_val("t7_lat", 64'(lat), 64'd15);
        check_val("t7_pass", 64'(pass_o), 64'd1);
        check_val("t7_sig", signature_o, GOLD3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
